ps2_transmitter: RTL and testbench



---
 rtl/ps2_transmitter_pkg.sv | 26 ++
 rtl/ps2_transmitter_debouncer.sv | 29 ++
 rtl/ps2_transmitter.sv | 180 ++++++++++++++++++
 tb/tb_ps2_transmitter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_transmitter_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
// Frame layout: data LSB first, then the odd parity bit, then the stop bit.
package ps2_transmitter_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE,
        S_ERROR
    } state_t;

    localparam logic [3:0] PAR_IDX  = 4'd8;
    localparam logic [3:0] STOP_IDX = 4'd9;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_transmitter_debouncer.sv
// Line filter: output follows the input only after it has held a new
// value for COUNT_MAX+1 consecutive cycles. Idles high like a PS/2 line.
module debouncer #(
    parameter int COUNT_MAX   = 19,
    parameter int COUNT_WIDTH = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [COUNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            dout <= 1'b1;
        end else if (din == dout) begin
            cnt <= '0;
        end else if (cnt == COUNT_WIDTH'(COUNT_MAX)) begin
            cnt  <= '0;
            dout <= din;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_transmitter.sv
// PS/2 host-to-device command transmitter: request-to-send, shift the
// frame out on device clocks, then check the device ack bit.
module ps2_transmitter
    import ps2_transmitter_pkg::*;
#(
    parameter int INHIBIT_CYCLES    = 12000,
    parameter int START_HOLD_CYCLES = 200,
    parameter int TIMEOUT_CYCLES    = 2000000,
    parameter int FILTER_MAX        = 19,
    parameter int FILTER_WIDTH      = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       kclk,
    input  logic       kdata,
    output logic       kclk_oe,
    output logic       kdata_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_t           state;
    logic [1:0]       kclk_s;
    logic [1:0]       kdata_s;
    logic             kclk_f;
    logic             kdata_f;
    logic             kclk_prev;
    logic             fall;
    logic [3:0]       bit_cnt;
    logic [PAR_IDX:0] sh;
    logic [31:0]      cnt;
    logic             tmo;

    always_ff @(posedge clk) begin
        if (rst) begin
            kclk_s    <= 2'b11;
            kdata_s   <= 2'b11;
            kclk_prev <= 1'b1;
            fall      <= 1'b0;
        end else begin
            kclk_s    <= {kclk_s[0], kclk};
            kdata_s   <= {kdata_s[0], kdata};
            kclk_prev <= kclk_f;
            fall      <= kclk_prev & ~kclk_f;
        end
    end

    debouncer #(
        .COUNT_MAX   (FILTER_MAX),
        .COUNT_WIDTH (FILTER_WIDTH)
    ) u_kclk_filt (
        .clk  (clk),
        .rst  (rst),
        .din  (kclk_s[1]),
        .dout (kclk_f)
    );

    debouncer #(
        .COUNT_MAX   (FILTER_MAX),
        .COUNT_WIDTH (FILTER_WIDTH)
    ) u_kdata_filt (
        .clk  (clk),
        .rst  (rst),
        .din  (kdata_s[1]),
        .dout (kdata_f)
    );

    assign tmo = (cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            tx_ready <= 1'b1;
            kclk_oe  <= 1'b0;
            kdata_oe <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            bit_cnt  <= '0;
            sh       <= '0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (tx_valid) begin
                        sh       <= {odd_parity(tx_data), tx_data};
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                        kclk_oe  <= 1'b1;
                        kdata_oe <= 1'b0;
                        cnt      <= '0;
                        state    <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (cnt == 32'(INHIBIT_CYCLES - 1)) begin
                        cnt      <= '0;
                        kdata_oe <= 1'b1;
                        state    <= S_START;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_START: begin
                    if (cnt == 32'(START_HOLD_CYCLES - 1)) begin
                        cnt     <= '0;
                        kclk_oe <= 1'b0;
                        bit_cnt <= '0;
                        state   <= S_SEND;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_SEND: begin
                    if (tmo) begin
                        err      <= 1'b1;
                        kclk_oe  <= 1'b0;
                        kdata_oe <= 1'b0;
                        state    <= S_ERROR;
                    end else begin
                        cnt <= cnt + 32'd1;
                        if (fall) begin
                            // ones shift in behind the frame, so bit 9 is the stop bit
                            kdata_oe <= ~sh[0];
                            sh       <= {1'b1, sh[PAR_IDX:1]};
                            bit_cnt  <= bit_cnt + 4'd1;
                            if (bit_cnt == STOP_IDX)
                                state <= S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    kdata_oe <= 1'b0;
                    if (tmo || (fall && kdata_f)) begin
                        err     <= 1'b1;
                        kclk_oe <= 1'b0;
                        state   <= S_ERROR;
                    end else begin
                        cnt <= cnt + 32'd1;
                        if (fall)
                            state <= S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (done) begin
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        bit_cnt  <= '0;
                        state    <= S_IDLE;
                    end else if (tmo) begin
                        err      <= 1'b1;
                        kclk_oe  <= 1'b0;
                        kdata_oe <= 1'b0;
                        state    <= S_ERROR;
                    end else begin
                        cnt <= cnt + 32'd1;
                        if (kclk_f && kdata_f)
                            done <= 1'b1;
                    end
                end
                S_ERROR: begin
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                    kclk_oe  <= 1'b0;
                    kdata_oe <= 1'b0;
                    bit_cnt  <= '0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_transmitter.sv
// Bench for ps2_transmitter: a PS/2 device model on the shared lines and
// a scoreboard of expected frames and done/err outcomes.
module tb_ps2_transmitter;
    import ps2_transmitter_pkg::*;

    localparam int INH  = 200;
    localparam int SH   = 20;
    localparam int TMO  = 3000;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, kclk_oe, kdata_oe, busy, done, err;

    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    logic dev_glitch = 1'b0;
    wire  kclk_line  = ~(kclk_oe | dev_clk_low | dev_glitch);
    wire  kdata_line = ~(kdata_oe | dev_data_low);

    int dev_mode  = 0;
    bit glitch_en = 1'b0;
    bit abort     = 1'b0;
    int dev_falls = 0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int         ev_q[$];
    logic [9:0] fr_q[$];

    ps2_transmitter #(
        .INHIBIT_CYCLES    (INH),
        .START_HOLD_CYCLES (SH),
        .TIMEOUT_CYCLES    (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .kclk     (kclk_line),
        .kdata    (kdata_line),
        .kclk_oe  (kclk_oe),
        .kdata_oe (kdata_oe),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s got event expected none", name);
    endtask

    // Monitor: phase lengths and done/err outcomes.
    initial begin
        logic p_kclk_oe, p_kdata_oe, pend;
        int t_inh, t_start, t_rel, last_rst, k;
        p_kclk_oe = 1'b0; p_kdata_oe = 1'b0; pend = 1'b0;
        t_inh = 0; t_start = 0; t_rel = 0; last_rst = 0;
        forever begin
            @(negedge clk);
            if (rst) last_rst = cyc;
            if (pend) begin
                check("after_pulse", {busy, tx_ready, kclk_oe, kdata_oe, done, err},
                      6'b010000);
                pend = 1'b0;
            end
            if (kclk_oe && !p_kclk_oe) t_inh = cyc;
            if (kdata_oe && !p_kdata_oe && kclk_oe) begin
                t_start = cyc;
                check("inhibit_len", cyc - t_inh, INH);
            end
            if (!kclk_oe && p_kclk_oe) begin
                t_rel = cyc;
                if (cyc - last_rst > 2)
                    check("start_hold", cyc - t_start, SH);
            end
            if (done || err) begin
                check("done_err_excl", done & err, 0);
                if (ev_q.size() == 0) begin
                    fail_now("unexpected_pulse");
                end else begin
                    k = ev_q.pop_front();
                    check("outcome", {done, err}, (k == 0) ? 2'b10 : 2'b01);
                    if (k == 2) check("timeout_len", cyc - t_rel, TMO);
                    if (err) check("err_lines", {kclk_oe, kdata_oe}, 0);
                    pend = 1'b1;
                end
            end
            p_kclk_oe  = kclk_oe;
            p_kdata_oe = kdata_oe;
        end
    end

    // Device model: answers request-to-send, clocks the frame, acks.
    initial begin
        logic [9:0] bits;
        forever begin
            @(negedge clk);
            if (!kclk_oe) continue;
            while (kclk_oe) @(negedge clk);
            check("start_bit", kdata_line, 0);
            if (dev_mode == 2) continue;
            bits = '0;
            repeat (HALF) @(negedge clk);
            for (int i = 0; i < 10 && !abort; i++) begin
                dev_clk_low = 1'b1;
                dev_falls++;
                repeat (HALF) @(negedge clk);
                dev_clk_low = 1'b0;
                bits[i] = kdata_line;
                for (int j = 0; j < HALF; j++) begin
                    dev_glitch = glitch_en && i == 3 && j == 10;
                    @(negedge clk);
                end
                dev_glitch = 1'b0;
            end
            if (abort) begin
                dev_clk_low = 1'b0;
                dev_data_low = 1'b0;
                continue;
            end
            dev_data_low = (dev_mode == 0);
            repeat (HALF / 2) @(negedge clk);
            dev_clk_low = 1'b1;
            dev_falls++;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (HALF / 2) @(negedge clk);
            dev_data_low = 1'b0;
            if (fr_q.size() == 0) fail_now("unexpected_frame");
            else check("frame", bits, fr_q.pop_front());
        end
    end

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            checks++;
            errors++;
            $display("FAIL send_wait got tx_ready=0 expected 1");
        end
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic drain(input int budget, input string nm);
        int n;
        n = 0;
        while ((ev_q.size() != 0 || fr_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ev_q.size() != 0 || fr_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s got %0d pending expected 0", nm,
                     ev_q.size() + fr_q.size());
            ev_q.delete();
            fr_q.delete();
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("reset_vals", {tx_ready, busy, kclk_oe, kdata_oe, done, err}, 6'b100000);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 0xED: 6 ones, odd parity 1
        ev_q.push_back(0); fr_q.push_back(10'h3ED);
        send(CMD_SET_LEDS);
        drain(5000, "ed");

        // back-to-back 0x01 (parity 0) then 0x00 (parity 1)
        ev_q.push_back(0); fr_q.push_back(10'h201);
        ev_q.push_back(0); fr_q.push_back(10'h300);
        send(8'h01);
        repeat (300) @(negedge clk);
        check("busy_mid", {tx_ready, busy}, 2'b01);
        send(8'h00);
        drain(5000, "b2b");

        // no ack from device: 0xAA has 4 ones, parity 1
        dev_mode = 1;
        ev_q.push_back(1); fr_q.push_back(10'h3AA);
        send(8'hAA);
        drain(5000, "nack");

        // device never clocks
        dev_mode = 2;
        ev_q.push_back(2);
        send(CMD_RESET);
        drain(6000, "timeout");
        dev_mode = 0;

        // reset mid-frame after the 4th falling edge
        dev_falls = 0;
        send(CMD_ENABLE);
        n = 0;
        while (dev_falls < 4 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("falls_reached", dev_falls >= 4, 1);
        repeat (30) @(negedge clk);
        abort = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1 check("rst_mid", {kclk_oe, kdata_oe, busy, tx_ready}, 4'b0001);
        @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        abort = 1'b0;
        ev_q.push_back(0); fr_q.push_back(10'h3FF);
        send(CMD_RESET);
        drain(5000, "after_rst");

        // one-cycle glitch on kclk during SEND; 0xF4 has 5 ones, parity 0
        glitch_en = 1'b1;
        ev_q.push_back(0); fr_q.push_back(10'h2F4);
        send(CMD_ENABLE);
        drain(5000, "glitch");
        glitch_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
